// File: rtl/alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl
//   Bit-serial sequencer around a 1-bit ALU slice. On a start request in IDLE
//   it latches two WIDTH-bit operands, a 3-bit function select and an initial
//   carry. It then presents one operand bit pair per clock to the slice, LSB
//   first. Each slice result bit Y is shifted into the result register from
//   the top, and the slice carry-out Cn_1 is fed back as the next Cn. After
//   WIDTH slice cycles the final carry-out is captured as cout, and done
//   pulses for one cycle.
//
// Ports
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   start              : operation request, only honoured in IDLE
//   op[2:0]            : slice function select, forwarded to {S2,S1,S0}
//   opa, opb [WIDTH]   : operands
//   cin                : carry into bit 0
//   busy               : high from the cycle after start through the done cycle
//   done               : one-cycle pulse, result/cout valid from here on
//   result [WIDTH]     : collected slice Y bits, bit i from slice cycle i
//   cout               : slice carry-out of the MSB cycle
//   A, B, Cn, S0..S2   : drive the slice
//   Y, Cn_1            : slice result and carry-out (combinational in A/B/Cn/S)
// -----------------------------------------------------------------------------
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             A,
  output logic             B,
  output logic             Cn,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  input  logic             Y,
  input  logic             Cn_1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value of the last (MSB) slice cycle.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_a;
  logic             w_b;
  logic             w_cn;

  // Sequencer FSM: operand capture, per-bit shifting and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_op     <= 3'b000;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sh_a   <= opa;
            r_sh_b   <= opb;
            r_op     <= op;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            // Hold: result and cout keep the last operation's values.
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // New bits enter at the MSB so that after WIDTH shifts the bit
          // produced in slice cycle i sits at result[i].
          r_result <= {Y, r_result[WIDTH-1:1]};
          r_carry  <= Cn_1;
          r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
          r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
          r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == LAST_CNT) begin
            r_cout  <= Cn_1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end
        end

        ST_DONE: begin
          // start is deliberately not sampled here; it is seen again in IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Slice operand drive: live bits only while running, zeros otherwise.
  always_comb begin
    w_a  = 1'b0;
    w_b  = 1'b0;
    w_cn = 1'b0;
    if (r_state == ST_RUN) begin
      w_a  = r_sh_a[0];
      w_b  = r_sh_b[0];
      w_cn = r_carry;
    end else begin
      w_a  = 1'b0;
      w_b  = 1'b0;
      w_cn = 1'b0;
    end
  end

  assign A      = w_a;
  assign B      = w_b;
  assign Cn     = w_cn;
  assign S0     = r_op[0];
  assign S1     = r_op[1];
  assign S2     = r_op[2];
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;

endmodule
